fpu_request_arbiter: RTL and testbench

- Shares the single fixed-point unit (2-bit op code: ADD, SUB, MUL, SQRT; level `ready` output) between two requesters with a round-robin grant.
- Latches the granted request and holds operands/operation stable on the unit's inputs until the unit signals ready.
- Returns the result to the owning requester over a valid/ready response channel.
- Sits between issue logic (e.g. core pipeline and a coprocessor port) and the fixed-point unit. Only one operation is outstanding at a time.

---
 rtl/fpu_request_arbiter.sv | 133 +++++++++++++
 tb/tb_fpu_request_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_request_arbiter.sv
// Round-robin arbiter sharing one fixed-point unit between two requesters.
// Holds the granted operation on the unit until ready, then returns the result.
module fpu_request_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_operand_1,
  input  logic [WIDTH-1:0] req0_operand_2,
  input  logic [1:0]       req0_operation,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_operand_1,
  input  logic [WIDTH-1:0] req1_operand_2,
  input  logic [1:0]       req1_operation,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_error,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_error,
  output logic [WIDTH-1:0] fpu_operand_1,
  output logic [WIDTH-1:0] fpu_operand_2,
  output logic [1:0]       fpu_operation,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic             owner;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic             grant;

  // With both requesters valid, the one not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      cnt           <= '0;
      fpu_operand_1 <= '0;
      fpu_operand_2 <= '0;
      fpu_operation <= 2'd0;
      rsp0_valid    <= 1'b0;
      rsp0_result   <= '0;
      rsp0_error    <= 1'b0;
      rsp1_valid    <= 1'b0;
      rsp1_result   <= '0;
      rsp1_error    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            fpu_operand_1 <= req0_operand_1;
            fpu_operand_2 <= req0_operand_2;
            fpu_operation <= req0_operation;
            owner         <= 1'b0;
            last_grant    <= 1'b0;
            state         <= ISSUE;
          end else if (req1_ready) begin
            fpu_operand_1 <= req1_operand_1;
            fpu_operand_2 <= req1_operand_2;
            fpu_operation <= req1_operation;
            owner         <= 1'b1;
            last_grant    <= 1'b1;
            state         <= ISSUE;
          end
        end
        // fpu_ready may still be high from the previous op, so it is not looked at here.
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (fpu_ready) begin
            if (owner) begin
              rsp1_result <= fpu_result;
              rsp1_error  <= 1'b0;
              rsp1_valid  <= 1'b1;
            end else begin
              rsp0_result <= fpu_result;
              rsp0_error  <= 1'b0;
              rsp0_valid  <= 1'b1;
            end
            state <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            if (owner) begin
              rsp1_result <= '0;
              rsp1_error  <= 1'b1;
              rsp1_valid  <= 1'b1;
            end else begin
              rsp0_result <= '0;
              rsp0_error  <= 1'b1;
              rsp0_valid  <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (owner ? rsp1_ready : rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_request_arbiter.sv
// Directed bench for fpu_request_arbiter: vector table plus hand-written
// sequences for stale ready, backpressure, timeout and mid-op reset.
module tb_fpu_request_arbiter;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_operand_1, req0_operand_2, req1_operand_1, req1_operand_2;
  logic [1:0]       req0_operation, req1_operation;
  logic             rsp0_valid, rsp0_ready, rsp0_error, rsp1_valid, rsp1_ready, rsp1_error;
  logic [WIDTH-1:0] rsp0_result, rsp1_result;
  logic [WIDTH-1:0] fpu_operand_1, fpu_operand_2, fpu_result;
  logic [1:0]       fpu_operation;
  logic             fpu_ready, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_request_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_operand_1(req0_operand_1), .req0_operand_2(req0_operand_2),
    .req0_operation(req0_operation),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_operand_1(req1_operand_1), .req1_operand_2(req1_operand_2),
    .req1_operation(req1_operation),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_error(rsp0_error),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_error(rsp1_error),
    .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
    .fpu_operation(fpu_operation), .fpu_result(fpu_result),
    .fpu_ready(fpu_ready), .busy(busy)
  );

  typedef struct {
    logic        v0, v1;
    logic [31:0] a0, a1, b;
    logic [1:0]  op0, op1;
    int          lat;
    logic [31:0] res;
    logic        own;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Full transaction: arbitration, issue, unit latency, response handshake.
  task automatic run_txn(input vec_t v, input string nm);
    req0_valid = v.v0; req1_valid = v.v1;
    req0_operand_1 = v.a0; req0_operand_2 = v.b; req0_operation = v.op0;
    req1_operand_1 = v.a1; req1_operand_2 = v.b; req1_operation = v.op1;
    #1;
    check({nm, ".req0_ready"}, 32'(req0_ready), 32'(v.v0 && !v.own));
    check({nm, ".req1_ready"}, 32'(req1_ready), 32'(v.v1 && v.own));
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_operand_1 = '1; req1_operand_1 = '1; req0_operation = 2'd3; req1_operation = 2'd3;
    fpu_ready = 1'b0;
    check({nm, ".busy_issue"}, 32'(busy), 32'd1);
    check({nm, ".fpu_op1"}, fpu_operand_1, v.own ? v.a1 : v.a0);
    check({nm, ".fpu_op2"}, fpu_operand_2, v.b);
    check({nm, ".fpu_opc"}, 32'(fpu_operation), 32'(v.own ? v.op1 : v.op0));
    repeat (1 + v.lat) @(negedge clk);
    check({nm, ".early_valid"}, 32'(rsp0_valid | rsp1_valid), 32'd0);
    check({nm, ".fpu_op1_held"}, fpu_operand_1, v.own ? v.a1 : v.a0);
    fpu_ready = 1'b1; fpu_result = v.res;
    @(negedge clk);
    fpu_ready = 1'b0; fpu_result = ~v.res;
    check({nm, ".own_valid"}, 32'(v.own ? rsp1_valid : rsp0_valid), 32'd1);
    check({nm, ".other_valid"}, 32'(v.own ? rsp0_valid : rsp1_valid), 32'd0);
    check({nm, ".result"}, v.own ? rsp1_result : rsp0_result, v.res);
    check({nm, ".error"}, 32'(v.own ? rsp1_error : rsp0_error), 32'd0);
    if (v.own) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    check({nm, ".valid_cleared"}, 32'(rsp0_valid | rsp1_valid), 32'd0);
    check({nm, ".busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //         v0 v1  a0          a1          b           op0   op1  lat res          own
    vecs[0] = '{1'b1, 1'b1, 32'h0100, 32'h0200, 32'h0300, 2'd2, 2'd1, 0, 32'h0000_4000, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0111, 32'h0222, 32'h0333, 2'd2, 2'd1, 2, 32'h0000_ABCD, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 32'h0A00, 32'h0B00, 32'h0C00, 2'd2, 2'd1, 1, 32'h1234_5678, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h0A01, 32'h0B01, 32'h0C01, 2'd2, 2'd1, 0, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 32'h0E80, 32'h0000, 32'h1040, 2'd0, 2'd0, 3, 32'h0000_1EC0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h5555, 32'h0000, 32'h2222, 2'd1, 2'd0, 0, 32'h8000_0001, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h0000, 32'h1CC00, 32'h0000, 2'd0, 2'd3, 1, 32'h0000_0055, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 32'h7777, 32'h8888, 32'h9999, 2'd3, 2'd0, 0, 32'h0000_0077, 1'b0};

    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_operand_1 = '0; req0_operand_2 = '0; req0_operation = 2'd0;
    req1_operand_1 = '0; req1_operand_2 = '0; req1_operation = 2'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    fpu_ready = 1'b0; fpu_result = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.rsp_valid", 32'(rsp0_valid | rsp1_valid), 32'd0);
    check("rst.fpu_op1", fpu_operand_1, 32'd0);
    check("rst.fpu_opc", 32'(fpu_operation), 32'd0);
    check("rst.rsp0_result", rsp0_result, 32'd0);
    check("rst.rsp1_error", 32'(rsp1_error), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Stale ready: unit ready still high while the new SQRT is in ISSUE.
    fpu_ready = 1'b1; fpu_result = 32'hDEAD_BEEF;
    req1_valid = 1'b1; req1_operand_1 = 32'h0001_CC00; req1_operand_2 = '0; req1_operation = 2'd3;
    #1 check("stale.req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    check("stale.fpu_op1", fpu_operand_1, 32'h0001_CC00);
    @(negedge clk);
    check("stale.no_resp_issue", 32'(rsp1_valid), 32'd0);
    fpu_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("stale.no_resp_wait", 32'(rsp1_valid), 32'd0);
    fpu_ready = 1'b1; fpu_result = 32'h0000_2AE6;
    @(negedge clk);
    fpu_ready = 1'b0;
    check("stale.rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("stale.rsp1_result", rsp1_result, 32'h0000_2AE6);
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;

    // Backpressure on rsp0 while req1 is pending.
    req0_valid = 1'b1; req0_operand_1 = 32'h0ABC; req0_operand_2 = 32'h0001; req0_operation = 2'd0;
    #1 check("bp.req0_ready", 32'(req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_operand_1 = 32'h0999; req1_operand_2 = 32'h0001; req1_operation = 2'd1;
    @(negedge clk);
    fpu_ready = 1'b1; fpu_result = 32'h00C0_FFEE;
    @(negedge clk);
    fpu_ready = 1'b0; fpu_result = '0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp.valid%0d", i), 32'(rsp0_valid), 32'd1);
      check($sformatf("bp.result%0d", i), rsp0_result, 32'h00C0_FFEE);
      check($sformatf("bp.req1_blocked%0d", i), 32'(req1_ready), 32'd0);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    #1 check("bp.req1_handshake_cycle", 32'(req1_ready), 32'd0);
    @(negedge clk);
    rsp0_ready = 1'b0;
    check("bp.rsp0_cleared", 32'(rsp0_valid), 32'd0);
    check("bp.req1_ready_after", 32'(req1_ready), 32'd1);
    v = '{1'b0, 1'b1, 32'h0, 32'h0999, 32'h0001, 2'd0, 2'd1, 0, 32'h0000_0998, 1'b1};
    run_txn(v, "bp_req1");

    // Timeout: unit never responds.
    req0_valid = 1'b1; req0_operand_1 = 32'h0333; req0_operand_2 = 32'h0001; req0_operation = 2'd1;
    #1 check("to.req0_ready", 32'(req0_ready), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0; fpu_ready = 1'b0;
    repeat (TIMEOUT) @(negedge clk);
    check("to.not_yet", 32'(rsp0_valid), 32'd0);
    @(negedge clk);
    check("to.valid", 32'(rsp0_valid), 32'd1);
    check("to.error", 32'(rsp0_error), 32'd1);
    check("to.result", rsp0_result, 32'd0);
    check("to.rsp1_quiet", 32'(rsp1_valid), 32'd0);
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    check("to.busy_done", 32'(busy), 32'd0);
    v = '{1'b1, 1'b0, 32'h0E80, 32'h0, 32'h1040, 2'd0, 2'd0, 1, 32'h0000_1EC0, 1'b0};
    run_txn(v, "post_to_add");

    // Asynchronous reset in WAIT discards the op and restores req0 priority.
    req0_valid = 1'b1; req0_operand_1 = 32'h0444; req0_operand_2 = 32'h0002; req0_operation = 2'd2;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    check("ar.busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("ar.busy", 32'(busy), 32'd0);
    check("ar.rsp_valid", 32'(rsp0_valid | rsp1_valid), 32'd0);
    check("ar.fpu_opc", 32'(fpu_operation), 32'd0);
    check("ar.fpu_op1", fpu_operand_1, 32'd0);
    check("ar.rsp0_result", rsp0_result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ar.no_resp", 32'(rsp0_valid | rsp1_valid), 32'd0);
    v = '{1'b1, 1'b1, 32'h0E80, 32'h0F00, 32'h1040, 2'd0, 2'd1, 0, 32'h0000_1EC0, 1'b0};
    run_txn(v, "ar_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
